// File: rtl/tt_toggle_pkg.sv
// Shared state encodings for the toggle receive checker and its pin wrapper.
package tt_toggle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Encodings the wrapper drives onto uo_out.
  localparam logic [1:0] STATE_IDLE_ENC   = 2'd0;
  localparam logic [1:0] STATE_SEARCH_ENC = 2'd1;
  localparam logic [1:0] STATE_LOCKED_ENC = 2'd2;

  // Bit positions of the status fields within uo_out.
  localparam int unsigned UO_STATE_LSB  = 0;
  localparam int unsigned UO_LOCKED_BIT = 2;
  localparam int unsigned UO_ERR_BIT    = 3;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous pin and flags any level change of the synced value.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic ds,
  output logic edge_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dp_q;

  // Flop chain into the clk domain, plus one more stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dp_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dp_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ds     = sync_q[SYNC_STAGES-1];
  assign edge_c = ds ^ dp_q;

endmodule

// File: rtl/toggle_rx_checker.sv
// Locks to a toggle stream of known half-period and counts timing errors.
module toggle_rx_checker
  import tt_toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned PERIOD_W    = 4,
  parameter int unsigned LOSS_COUNT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                din,
  input  logic [PERIOD_W-1:0] expect_period,
  input  logic                clr_err,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_count,
  output logic [1:0]          state
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_COUNT + 1);

  state_e              st;
  logic [PERIOD_W-1:0] cnt;
  logic [GOOD_W-1:0]   good;
  logic [BAD_W-1:0]    bad;
  logic                primed;
  logic                timed_out;

  logic                ds_unused;
  logic                edge_c;
  logic [PERIOD_W-1:0] p_eff_c;
  logic [PERIOD_W:0]   run_c;
  logic                run_match_c;
  logic                timeout_c;
  logic                err_event_c;
  logic [PERIOD_W-1:0] cnt_next_c;
  logic [GOOD_W-1:0]   good_inc_c;
  logic [BAD_W-1:0]    bad_inc_c;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .ds    (ds_unused),
    .edge_c(edge_c)
  );

  // Run measurement, error detection and saturating increments.
  always_comb begin
    p_eff_c     = (expect_period == '0) ? PERIOD_W'(1) : expect_period;
    run_c       = {1'b0, cnt} + (PERIOD_W + 1)'(1);
    run_match_c = (run_c == {1'b0, p_eff_c});
    timeout_c   = !edge_c && (cnt == p_eff_c) && !timed_out;
    err_event_c = ena && (st == ST_LOCKED) &&
                  ((edge_c && !run_match_c && !timed_out) || timeout_c);
    cnt_next_c  = edge_c ? '0 : ((&cnt) ? cnt : cnt + PERIOD_W'(1));
    good_inc_c  = (good == GOOD_W'(LOCK_COUNT)) ? good : good + GOOD_W'(1);
    bad_inc_c   = (bad == BAD_W'(LOSS_COUNT)) ? bad : bad + BAD_W'(1);
  end

  // Error outputs; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= err_event_c;
      if (clr_err) begin
        err_count <= '0;
      end else if (err_event_c && !(&err_count)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  // Lock FSM with run counter and good/bad streak tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      locked    <= 1'b0;
      cnt       <= '0;
      good      <= '0;
      bad       <= '0;
      primed    <= 1'b0;
      timed_out <= 1'b0;
    end else if (!ena) begin
      st        <= ST_IDLE;
      locked    <= 1'b0;
      cnt       <= '0;
      good      <= '0;
      bad       <= '0;
      primed    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          st  <= ST_SEARCH;
          cnt <= '0;
        end
        ST_SEARCH: begin
          cnt <= cnt_next_c;
          if (edge_c) begin
            if (!primed) begin
              primed <= 1'b1;
            end else if (run_match_c) begin
              good <= good_inc_c;
              if (good_inc_c == GOOD_W'(LOCK_COUNT)) begin
                st        <= ST_LOCKED;
                locked    <= 1'b1;
                bad       <= '0;
                timed_out <= 1'b0;
              end
            end else begin
              good <= '0;
            end
          end
        end
        ST_LOCKED: begin
          cnt <= cnt_next_c;
          if (edge_c) begin
            timed_out <= 1'b0;
          end else if (timeout_c) begin
            timed_out <= 1'b1;
          end
          if (err_event_c) begin
            if (bad_inc_c == BAD_W'(LOSS_COUNT)) begin
              st     <= ST_SEARCH;
              locked <= 1'b0;
              good   <= '0;
              primed <= 1'b0;
              bad    <= '0;
            end else begin
              bad <= bad_inc_c;
            end
          end else if (edge_c && run_match_c) begin
            bad <= '0;
          end
        end
        default: begin
          st     <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_toggle_rx_checker.sv
// Directed bench for toggle_rx_checker with hand-computed expectations.
module tb_toggle_rx_checker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       din;
  logic [3:0] expect_period;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [1:0] state;

  int checks;
  int errors;
  int pulses;
  int saw_lock;

  toggle_rx_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .din          (din),
    .expect_period(expect_period),
    .clr_err      (clr_err),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One toggle per clock, with pulse counting.
  task automatic toggle_n(input int n);
    for (int i = 0; i < n; i++) begin
      din = ~din;
      tick();
      if (err_pulse) pulses++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0; saw_lock = 0;
    rst_n = 1'b0; ena = 1'b0; din = 1'b0; expect_period = 4'd0; clr_err = 1'b0;

    // 1: reset values, IDLE holds while disabled
    #3;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_state", 32'(state), 0);
    #9 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      tick();
    end
    chk("idle_state_toggling", 32'(state), 0);
    din = 1'b0;
    repeat (4) tick();

    // 2: P=0 behaves as P=1, lock after priming + 16 good edges
    ena = 1'b1;
    tick();
    chk("search_entry", 32'(state), 1);
    for (int j = 0; j <= 18; j++) begin
      din = ~din;
      tick();
      chk($sformatf("lock_p1_j%0d", j), 32'(locked), (j >= 18) ? 1 : 0);
    end
    chk("lock_p1_state", 32'(state), 2);
    chk("lock_p1_errcnt", 32'(err_count), 0);
    expect_period = 4'd1;
    toggle_n(4);

    // 3: one 3-cycle stall gives a single timeout error
    pulses = 0;
    tick(); if (err_pulse) pulses++;
    tick(); if (err_pulse) pulses++;
    toggle_n(10);
    chk("stall_pulses", 32'(pulses), 1);
    chk("stall_errcnt", 32'(err_count), 1);
    chk("stall_locked", 32'(locked), 1);

    // 4: half-period of 2 at P=1 drops lock after 4 errors
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) din = ~din;
      tick();
      if (err_pulse) pulses++;
    end
    chk("mismatch_pulses", 32'(pulses), 4);
    chk("mismatch_state", 32'(state), 1);
    chk("mismatch_locked", 32'(locked), 0);
    chk("mismatch_errcnt", 32'(err_count), 5);
    saw_lock = 0;
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) din = ~din;
      tick();
      if (locked) saw_lock = 1;
    end
    chk("mismatch_no_relock", saw_lock, 0);

    // 5: saturation of err_count, then clear beating an increment
    for (int k = 0; k < 60 && !locked; k++) begin
      din = ~din;
      tick();
    end
    chk("relock_p1", 32'(locked), 1);
    for (int g = 0; g < 300; g++) begin
      din = ~din; tick(); tick();
      din = ~din; tick();
    end
    chk("sat_errcnt", 32'(err_count), 255);
    chk("sat_locked", 32'(locked), 1);
    for (int g = 0; g < 5; g++) begin
      din = ~din; tick(); tick();
      din = ~din; tick();
    end
    chk("sat_hold", 32'(err_count), 255);
    din = ~din; tick(); tick();
    din = ~din; tick();
    din = ~din; tick();
    clr_err = 1'b1;
    din = ~din; tick();
    clr_err = 1'b0;
    chk("clr_vs_err_pulse", 32'(err_pulse), 1);
    chk("clr_vs_err_count", 32'(err_count), 0);

    // 6: disable mid-lock holds err_count
    pulses = 0;
    toggle_n(5);
    tick(); tick();
    toggle_n(10);
    chk("pre_dis_errcnt", 32'(err_count), 1);
    chk("pre_dis_locked", 32'(locked), 1);
    ena = 1'b0;
    din = ~din; tick();
    chk("dis_state", 32'(state), 0);
    chk("dis_locked", 32'(locked), 0);
    chk("dis_errcnt", 32'(err_count), 1);

    // 6b: async reset mid-lock
    ena = 1'b1;
    for (int k = 0; k < 60 && !locked; k++) begin
      din = ~din;
      tick();
    end
    chk("relock_before_rst", 32'(locked), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_errcnt", 32'(err_count), 0);
    chk("arst_err_pulse", 32'(err_pulse), 0);
    ena = 1'b0; din = 1'b0; expect_period = 4'd3;
    #2 rst_n = 1'b1;
    repeat (3) tick();

    // 6c: relock at P=3 after priming + 16 edges
    ena = 1'b1;
    tick();
    chk("p3_search", 32'(state), 1);
    for (int j = 0; j <= 51; j++) begin
      if (j % 3 == 0) din = ~din;
      tick();
      chk($sformatf("lock_p3_j%0d", j), 32'(locked), (j >= 50) ? 1 : 0);
    end
    chk("p3_errcnt", 32'(err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
